decoder_grant_arbiter: RTL and testbench

//  Round-robin arbiter: 8 requesters share one 3-bit select path that drives a 3-to-8 decoder.

---
 rtl/decoder_grant_arbiter_pkg.sv | 14 +
 rtl/decoder_grant_arbiter_if.sv | 31 +++
 rtl/decoder_grant_arbiter_dec.sv | 16 +
 rtl/decoder_grant_arbiter.sv | 130 +++++++++++++
 tb/tb_decoder_grant_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/decoder_grant_arbiter_pkg.sv
// Shared constants for the decoded-select round-robin arbiter.
// The optional preemption limit (ARB_TIMEOUT_EN) uses MAX_HOLD/HOLD_W.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam int MAX_HOLD = 15;
    localparam int HOLD_W   = 4;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

endpackage

// File: rtl/decoder_grant_arbiter_if.sv
// Request/grant bundle between the request sources and the arbiter.
// master = requester side, slave = arbiter side.
interface decoder_grant_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/decoder_grant_arbiter_dec.sv
// Shared 3-to-8 select decoder with active-high enable.
// All outputs are low while en is low.
module decoder_3x8 (
    input  logic [2:0] d,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        if (en) begin
            y[d] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_grant_arbiter.sv
// Round-robin owner arbiter feeding a shared 3-to-8 select decoder.
// Define ARB_TIMEOUT_EN to preempt owners holding longer than MAX_HOLD.
import arb_pkg::*;

module decoder_grant_arbiter (
    input  logic                         clk,
    input  logic                         rst,
    decoder_grant_arbiter_if.slave       bus
);

    logic             state_q;
    logic             state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ptr_q;
    logic             rel;
    logic             drop;
    logic             take;
    logic             valid;
    logic [N_REQ-1:0] gnt;

    // First set request after p, wrapping mod 8; p itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [IDX_W-1:0] p,
        input logic [N_REQ-1:0] r
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             hit;
        win = p;
        hit = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = p + IDX_W'(i);
            if (!hit && r[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
        return win;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q;
    logic              pre;
    logic              timeout_q;

    always_comb begin
        pre = 1'b0;
        if (state_q == GRANT && !rel) begin
            pre = (hold_q == HOLD_W'(MAX_HOLD));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= pre;
            if (take) begin
                hold_q <= '0;
            end else if (state_q == GRANT && !drop &&
                         hold_q != HOLD_W'(MAX_HOLD)) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign drop        = rel | pre;
    assign bus.timeout = timeout_q;
`else
    assign drop        = rel;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        rel = 1'b0;
        if (state_q == GRANT) begin
            rel = bus.done | ~bus.req[idx_q];
        end
    end

    assign take = (state_q == IDLE) && (|bus.req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            if (take) begin
                idx_q <= rr_pick(ptr_q, bus.req);
            end
            if (drop) begin
                ptr_q <= idx_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (drop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid         = (state_q == GRANT);
        bus.gnt_valid = valid;
        bus.gnt_idx   = idx_q;
        bus.gnt       = gnt;
    end

    decoder_3x8 u_dec (
        .d  (idx_q),
        .en (valid),
        .y  (gnt)
    );

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Directed bench for decoder_grant_arbiter.
// Build with +define+ARB_TIMEOUT_EN to exercise owner preemption.
module tb_decoder_grant_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decoder_grant_arbiter_if bus ();

    decoder_grant_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_gnt(input string tag, input logic [7:0] exp);
        check(tag, bus.gnt, exp);
        check({tag, "_v"}, {7'd0, bus.gnt_valid}, {7'd0, exp != 8'h00});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.req  = 8'hFF;
        bus.done = 1'b0;

        // T1: reset state, requester 0 wins first
        step();
        step();
        check_gnt("t1_rst_gnt", 8'h00);
        check("t1_rst_idx", {5'd0, bus.gnt_idx}, 8'd0);
        check("t1_rst_to", {7'd0, bus.timeout}, 8'd0);
        rst = 1'b0;
        step();
        check_gnt("t1_first", 8'h01);
        check("t1_idx", {5'd0, bus.gnt_idx}, 8'd0);

        // T2: full rotation with done pulses
        for (int k = 0; k < 8; k++) begin
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            check_gnt($sformatf("t2_gap%0d", k), 8'h00);
            check("t2_to", {7'd0, bus.timeout}, 8'd0);
            step();
            check_gnt($sformatf("t2_own%0d", k), 8'h01 << ((k + 1) % 8));
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        check_gnt("t2_end", 8'h00);

        // T3: set ptr=2, then 8'b1000_0100 picks 7, then wraps to 2
        bus.req = 8'h04;
        step();
        check_gnt("t3_pre", 8'h04);
        bus.req = 8'h00;
        step();
        check_gnt("t3_rel", 8'h00);
        bus.req = 8'h84;
        step();
        check_gnt("t3_w7", 8'h80);
        check("t3_idx7", {5'd0, bus.gnt_idx}, 8'd7);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check_gnt("t3_gap", 8'h00);
        step();
        check_gnt("t3_w2", 8'h04);
        bus.req = 8'h00;
        step();
        check_gnt("t3_end", 8'h00);

        // T4: owner 3 drops req together with done; 5 is next
        bus.req = 8'h28;
        step();
        check_gnt("t4_w3", 8'h08);
        bus.req  = 8'h20;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check_gnt("t4_gap", 8'h00);
        step();
        check_gnt("t4_w5", 8'h20);
        check("t4_idx5", {5'd0, bus.gnt_idx}, 8'd5);
        bus.req = 8'h00;
        step();
        check_gnt("t4_rel", 8'h00);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check_gnt("t4_idle_done", 8'h00);

        // T5: async reset mid-grant
        bus.req = 8'hFF;
        step();
        check_gnt("t5_w6", 8'h40);
        #2;
        rst = 1'b1;
        #1;
        check_gnt("t5_async", 8'h00);
        step();
        rst = 1'b0;
        step();
        check_gnt("t5_after", 8'h01);

        // T6: requester 4 holds without done
        bus.req = 8'h10;
        step();
        check_gnt("t6_drop0", 8'h00);
        step();
        check_gnt("t6_w4", 8'h10);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            step();
            check_gnt($sformatf("t6_hold%0d", k), 8'h10);
            check("t6_to_lo", {7'd0, bus.timeout}, 8'd0);
        end
        step();
        check_gnt("t6_preempt", 8'h00);
        check("t6_to_hi", {7'd0, bus.timeout}, 8'd1);
        step();
        check("t6_to_pulse", {7'd0, bus.timeout}, 8'd0);
        check_gnt("t6_regrant", 8'h10);
`else
        for (int k = 0; k < 100; k++) begin
            step();
            check($sformatf("t6_hold%0d", k), bus.gnt, 8'h10);
            check("t6_to", {7'd0, bus.timeout}, 8'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
